// File: rtl/pipe_multiplier_pkg.sv
// rtl/pipe_multiplier_pkg.sv - shared types, defaults and saturation/rounding helpers for pipe_multiplier
package pipe_multiplier_pkg;

  localparam int DEF_W      = 32;
  localparam int DEF_STAGES = 3;
  localparam int DEF_FRAC   = 16;

  // Wide enough to hold any 2W+1 bit intermediate for W up to 64.
  localparam int SAT_BITS = 130;

  typedef logic signed [SAT_BITS-1:0] sat_word_t;

  typedef struct packed {
    logic valid;
    logic is_signed;
  } slot_flags_t;

  function automatic sat_word_t sat_max(input int w, input logic is_signed);
    sat_word_t one;
    one = sat_word_t'(1);
    return is_signed ? (one << (w - 1)) - one : (one << w) - one;
  endfunction

  function automatic sat_word_t sat_min(input int w, input logic is_signed);
    sat_word_t one;
    one = sat_word_t'(1);
    return is_signed ? -(one << (w - 1)) : sat_word_t'(0);
  endfunction

  // Half an output LSB, added before the shift for round-half-up.
  function automatic sat_word_t round_const(input int frac);
    sat_word_t one;
    one = sat_word_t'(1);
    return (frac == 0) ? sat_word_t'(0) : (one << (frac - 1));
  endfunction

endpackage

// File: rtl/mult_quantise.sv
// rtl/mult_quantise.sv - product shift/saturate to W bits; PIPE_MULTIPLIER_ROUND_EN adds half-LSB rounding
module mult_quantise
  import pipe_multiplier_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic [2*W-1:0] prod,
  input  logic           is_signed,
  output logic [W-1:0]   q,
  output logic           ovf
);

  localparam int EW = 2 * W + 1;

`ifdef PIPE_MULTIPLIER_ROUND_EN
  localparam sat_word_t RC = round_const(FRAC);
`endif

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] adj;
  logic signed [EW-1:0] shifted;
  sat_word_t            r_wide;
  sat_word_t            hi;
  sat_word_t            lo;

  // One extra bit keeps the unsigned product non-negative so a single arithmetic shift serves both modes.
  always_comb begin
    ext = is_signed ? {prod[2*W-1], prod} : {1'b0, prod};
`ifdef PIPE_MULTIPLIER_ROUND_EN
    adj = ext + RC[EW-1:0];
`else
    adj = ext;
`endif
    shifted = adj >>> FRAC;
    r_wide  = {{(SAT_BITS-EW){shifted[EW-1]}}, shifted};
    hi      = sat_max(W, is_signed);
    lo      = sat_min(W, is_signed);
    q       = shifted[W-1:0];
    ovf     = 1'b0;
    if (r_wide > hi) begin
      q   = hi[W-1:0];
      ovf = 1'b1;
    end else if (r_wide < lo) begin
      q   = lo[W-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_multiplier.sv
// rtl/pipe_multiplier.sv - pipelined signed/unsigned fixed-point multiplier with valid/ready; PIPE_MULTIPLIER_ROUND_EN selects rounding
module pipe_multiplier
  import pipe_multiplier_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int STAGES = DEF_STAGES,
  parameter int FRAC   = DEF_FRAC
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   Data_A_i,
  input  logic [W-1:0]   Data_B_i,
  input  logic           Signed_i,
  input  logic           Valid_i,
  output logic           Ready_o,
  output logic [2*W-1:0] Data_S_o,
  output logic [W-1:0]   Data_Q_o,
  output logic           Ovf_o,
  output logic           Valid_o,
  input  logic           Ready_i,
  output logic           Busy_o
);

  typedef struct packed {
    slot_flags_t      flags;
    logic [2*W-1:0]   product;
  } mult_slot_t;

  mult_slot_t     slots [STAGES];
  logic           adv;
  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] prod_in;

  // The whole pipe moves as one; only a blocked output can stall it.
  assign adv     = ~slots[STAGES-1].flags.valid | Ready_i;
  assign Ready_o = adv;

  always_comb begin
    a_ext   = Signed_i ? {{W{Data_A_i[W-1]}}, Data_A_i} : {{W{1'b0}}, Data_A_i};
    b_ext   = Signed_i ? {{W{Data_B_i[W-1]}}, Data_B_i} : {{W{1'b0}}, Data_B_i};
    prod_in = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        slots[i] <= '0;
      end
    end else if (adv) begin
      slots[0].flags.valid     <= Valid_i & adv;
      slots[0].flags.is_signed <= Signed_i;
      slots[0].product         <= prod_in;
      for (int i = 1; i < STAGES; i++) begin
        slots[i] <= slots[i-1];
      end
    end
  end

  always_comb begin
    Busy_o = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      Busy_o = Busy_o | slots[i].flags.valid;
    end
  end

  assign Valid_o  = slots[STAGES-1].flags.valid;
  assign Data_S_o = slots[STAGES-1].product;

  mult_quantise #(
    .W    (W),
    .FRAC (FRAC)
  ) u_quantise (
    .prod      (slots[STAGES-1].product),
    .is_signed (slots[STAGES-1].flags.is_signed),
    .q         (Data_Q_o),
    .ovf       (Ovf_o)
  );

endmodule
